// File: rtl/mux_pkg.sv
`default_nettype none
// mux_pkg: shared defaults, select-legality helper and handshake state type for mux_reg_n.
// Rev 1.0
package mux_pkg;

  localparam int DEFAULT_WIDTH     = 32;
  localparam int DEFAULT_ERR_CNT_W = 8;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } hs_state_t;

  function automatic logic sel_legal(input int unsigned sel, input int unsigned num_in);
    return sel < num_in;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mux_reg_n_sat_counter.sv
`default_nettype none
// sat_counter: W-bit up-counter with increment enable and synchronous active-low clear; sticks at all-ones.
// Rev 1.0
module sat_counter
  import mux_pkg::*;
#(
  parameter int W = DEFAULT_ERR_CNT_W
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      count_q <= '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/mux_reg_n.sv
`default_nettype none
// mux_reg_n: NUM_IN-way select into a single-entry valid/ready output register with illegal-select counting.
// Rev 1.0 -- optional out_sel trace port under MUX_REG_SEL_TRACE_EN.
module mux_reg_n
  import mux_pkg::*;
#(
  parameter  int NUM_IN    = 3,
  parameter  int WIDTH     = DEFAULT_WIDTH,
  parameter  int ERR_CNT_W = DEFAULT_ERR_CNT_W,
  localparam int SEL_W     = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err,
  output logic [ERR_CNT_W-1:0]    err_count
`ifdef MUX_REG_SEL_TRACE_EN
  ,
  output logic [SEL_W-1:0]        out_sel
`endif
);

  hs_state_t        state;
  hs_state_t        state_next;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] sel_data;
  logic             sel_err_q;
  logic             legal;
  logic             illegal;
  logic             accept;
  logic             drain;

  // Unmatched codes fall through to zero; they never reach the register anyway.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (in_sel == SEL_W'(k)) begin
        sel_data = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  assign legal    = sel_legal(32'(in_sel), NUM_IN);
  assign in_ready = (state == EMPTY) || out_ready;
  assign accept   = in_valid && in_ready && legal;
  assign illegal  = in_valid && !legal;
  assign drain    = (state == FULL) && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (accept) begin
      state_next = FULL;
    end else if (drain) begin
      state_next = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q    <= '0;
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= illegal;
      if (accept) begin
        data_q <= sel_data;
      end
    end
  end

  sat_counter #(
    .W (ERR_CNT_W)
  ) u_err_cnt (
    .clk   (clk),
    .clr_n (rst_n),
    .inc   (illegal),
    .count (err_count)
  );

`ifdef MUX_REG_SEL_TRACE_EN
  logic [SEL_W-1:0] sel_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_q <= '0;
    end else if (accept) begin
      sel_q <= in_sel;
    end
  end

  assign out_sel = sel_q;
`endif

  assign out_data  = data_q;
  assign out_valid = (state == FULL);
  assign sel_err   = sel_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_reg_n.sv
`default_nettype none
// tb_mux_reg_n: directed and random checks of two mux_reg_n configurations against a behavioural model.
// Rev 1.0
module tb_mux_reg_n;

  localparam int A_N = 3;
  localparam int A_W = 32;
  localparam int A_E = 2;
  localparam int B_N = 8;
  localparam int B_W = 16;
  localparam int B_E = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               a_rst_n, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_sel_err;
  logic [A_N*A_W-1:0] a_in_data;
  logic [1:0]         a_in_sel;
  logic [A_W-1:0]     a_out_data;
  logic [A_E-1:0]     a_err_count;

  logic               b_rst_n, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_sel_err;
  logic [B_N*B_W-1:0] b_in_data;
  logic [2:0]         b_in_sel;
  logic [B_W-1:0]     b_out_data;
  logic [B_E-1:0]     b_err_count;

`ifdef MUX_REG_SEL_TRACE_EN
  logic [1:0] a_out_sel;
  logic [2:0] b_out_sel;
`endif

  mux_reg_n #(.NUM_IN(A_N), .WIDTH(A_W), .ERR_CNT_W(A_E)) dut_a (
    .clk       (clk),
    .rst_n     (a_rst_n),
    .in_data   (a_in_data),
    .in_sel    (a_in_sel),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .out_data  (a_out_data),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .sel_err   (a_sel_err),
    .err_count (a_err_count)
`ifdef MUX_REG_SEL_TRACE_EN
    ,
    .out_sel   (a_out_sel)
`endif
  );

  mux_reg_n #(.NUM_IN(B_N), .WIDTH(B_W), .ERR_CNT_W(B_E)) dut_b (
    .clk       (clk),
    .rst_n     (b_rst_n),
    .in_data   (b_in_data),
    .in_sel    (b_in_sel),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .out_data  (b_out_data),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .sel_err   (b_sel_err),
    .err_count (b_err_count)
`ifdef MUX_REG_SEL_TRACE_EN
    ,
    .out_sel   (b_out_sel)
`endif
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference state: what the output register should hold after each edge.
  bit          am_valid, am_err;
  logic [31:0] am_data;
  int          am_cnt, am_sel;
  bit          bm_valid, bm_err;
  logic [15:0] bm_data;
  int          bm_cnt, bm_sel;

  task automatic step_a();
    bit ill, rdy, acc;
    int unsigned s;
    #1;
    check("a_in_ready", 64'(a_in_ready), 64'(!am_valid || a_out_ready));
    @(posedge clk);
    s = int'(a_in_sel);
    if (!a_rst_n) begin
      am_valid = 0; am_data = '0; am_err = 0; am_cnt = 0; am_sel = 0;
    end else begin
      ill    = a_in_valid && (s >= A_N);
      rdy    = !am_valid || a_out_ready;
      acc    = a_in_valid && rdy && !ill;
      am_err = ill;
      if (ill && am_cnt < (1 << A_E) - 1) am_cnt++;
      if (acc) begin
        am_data  = 32'(a_in_data >> (s * A_W));
        am_sel   = int'(s);
        am_valid = 1;
      end else if (am_valid && a_out_ready) begin
        am_valid = 0;
      end
    end
    #1;
    check("a_out_data", 64'(a_out_data), 64'(am_data));
    check("a_out_valid", 64'(a_out_valid), 64'(am_valid));
    check("a_sel_err", 64'(a_sel_err), 64'(am_err));
    check("a_err_count", 64'(a_err_count), 64'(am_cnt));
`ifdef MUX_REG_SEL_TRACE_EN
    check("a_out_sel", 64'(a_out_sel), 64'(am_sel));
`endif
  endtask

  task automatic step_b();
    bit ill, rdy, acc;
    int unsigned s;
    #1;
    check("b_in_ready", 64'(b_in_ready), 64'(!bm_valid || b_out_ready));
    @(posedge clk);
    s = int'(b_in_sel);
    if (!b_rst_n) begin
      bm_valid = 0; bm_data = '0; bm_err = 0; bm_cnt = 0; bm_sel = 0;
    end else begin
      ill    = b_in_valid && (s >= B_N);
      rdy    = !bm_valid || b_out_ready;
      acc    = b_in_valid && rdy && !ill;
      bm_err = ill;
      if (ill && bm_cnt < (1 << B_E) - 1) bm_cnt++;
      if (acc) begin
        bm_data  = 16'(b_in_data >> (s * B_W));
        bm_sel   = int'(s);
        bm_valid = 1;
      end else if (bm_valid && b_out_ready) begin
        bm_valid = 0;
      end
    end
    #1;
    check("b_out_data", 64'(b_out_data), 64'(bm_data));
    check("b_out_valid", 64'(b_out_valid), 64'(bm_valid));
    check("b_sel_err", 64'(b_sel_err), 64'(bm_err));
    check("b_err_count", 64'(b_err_count), 64'(bm_cnt));
`ifdef MUX_REG_SEL_TRACE_EN
    check("b_out_sel", 64'(b_out_sel), 64'(bm_sel));
`endif
  endtask

  initial begin
    int exp_sat[5] = '{1, 2, 3, 3, 3};

    a_rst_n = 0; a_in_valid = 0; a_out_ready = 0; a_in_sel = '0;
    a_in_data = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    b_rst_n = 0; b_in_valid = 0; b_out_ready = 0; b_in_sel = '0; b_in_data = '0;

    // Reset state
    step_a();
    step_a();
    check("rst_valid", 64'(a_out_valid), 64'd0);
    check("rst_data", 64'(a_out_data), 64'd0);

    // Basic select
    a_rst_n = 1; a_in_sel = 2'd1; a_in_valid = 1; a_out_ready = 1;
    step_a();
    check("basic_data", 64'(a_out_data), 64'h2222_2222);
    check("basic_valid", 64'(a_out_valid), 64'd1);

    // Backpressure, then same-cycle drain+accept
    a_out_ready = 0; a_in_sel = 2'd2;
    #1;
    check("bp_in_ready", 64'(a_in_ready), 64'd0);
    step_a();
    check("bp_hold", 64'(a_out_data), 64'h2222_2222);
    a_out_ready = 1;
    step_a();
    check("drain_accept", 64'(a_out_data), 64'h3333_3333);
    check("drain_accept_v", 64'(a_out_valid), 64'd1);

    // Illegal select while FULL
    a_out_ready = 0; a_in_sel = 2'd3;
    step_a();
    check("ill_err", 64'(a_sel_err), 64'd1);
    check("ill_cnt", 64'(a_err_count), 64'd1);
    check("ill_data", 64'(a_out_data), 64'h3333_3333);
    a_in_valid = 0;
    step_a();
    check("ill_err_drop", 64'(a_sel_err), 64'd0);

    // Saturation from a fresh reset
    a_rst_n = 0;
    step_a();
    a_rst_n = 1; a_in_valid = 1; a_in_sel = 2'd3;
    for (int i = 0; i < 5; i++) begin
      step_a();
      check("sat_cnt", 64'(a_err_count), 64'(exp_sat[i]));
      check("sat_err", 64'(a_sel_err), 64'd1);
    end

    // Reset mid-operation overriding a legal accept
    a_rst_n = 0; a_in_valid = 0;
    step_a();
    a_rst_n = 1; a_in_valid = 1; a_in_sel = 2'd3;
    step_a();
    step_a();
    a_in_sel = 2'd0;
    step_a();
    check("mid_cnt_pre", 64'(a_err_count), 64'd2);
    a_rst_n = 0; a_in_sel = 2'd1; a_out_ready = 1;
    step_a();
    check("mid_rst_valid", 64'(a_out_valid), 64'd0);
    check("mid_rst_data", 64'(a_out_data), 64'd0);
    check("mid_rst_cnt", 64'(a_err_count), 64'd0);
    check("mid_rst_err", 64'(a_sel_err), 64'd0);

    // Random traffic on the 3-input instance
    for (int i = 0; i < 300; i++) begin
      a_rst_n     = ($urandom_range(0, 29) != 0);
      a_in_valid  = $urandom_range(0, 3) != 0;
      a_out_ready = $urandom_range(0, 2) != 0;
      a_in_sel    = 2'($urandom_range(0, 3));
      a_in_data   = {$urandom, $urandom, $urandom};
      step_a();
    end
    a_rst_n = 0; a_in_valid = 0;

    // 8-input, 16-bit instance: stream every select code
    step_b();
    step_b();
    b_rst_n = 1; b_in_valid = 1; b_out_ready = 1;
    for (int k = 0; k < B_N; k++) begin
      b_in_sel  = 3'(k);
      b_in_data = {$urandom, $urandom, $urandom, $urandom};
      step_b();
      check("stream_data", 64'(b_out_data), 64'(16'(b_in_data >> (k * B_W))));
      check("stream_err", 64'(b_sel_err), 64'd0);
`ifdef MUX_REG_SEL_TRACE_EN
      check("stream_sel", 64'(b_out_sel), 64'(k));
`endif
    end
    for (int i = 0; i < 300; i++) begin
      b_rst_n     = ($urandom_range(0, 29) != 0);
      b_in_valid  = $urandom_range(0, 3) != 0;
      b_out_ready = $urandom_range(0, 2) != 0;
      b_in_sel    = 3'($urandom_range(0, 7));
      b_in_data   = {$urandom, $urandom, $urandom, $urandom};
      step_b();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mux_reg_n.md
Name: mux_reg_n

Overview:
- Parametrised N-input, WIDTH-bit select-and-register stage for the multicycle datapath; generalises the fixed 3-input/32-bit operand select.
- Selects one of NUM_IN packed inputs and captures it into a single-entry output register under a valid/ready handshake.
- Output holds its value between captures, so there is no latch and no undefined output on unused select codes.
- Rejects out-of-range select codes, pulses an error and counts them.

Parameters:
- NUM_IN, 3, number of data inputs (2..16).
- WIDTH, 32, data width in bits.
- SEL_W, $clog2(NUM_IN), select width; derived, not overridden.
- ERR_CNT_W, 8, width of the saturating illegal-select counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active low.
- in_data  input  NUM_IN*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH].
- in_sel  input  SEL_W  select code.
- in_valid  input  1  in_data/in_sel valid this cycle.
- in_ready  output  1  stage can accept.
- out_data  output  WIDTH  registered selected data.
- out_valid  output  1  out_data holds an unconsumed value.
- out_ready  input  1  consumer accepts out_data.
- sel_err  output  1  registered one-cycle pulse: an illegal select was presented with in_valid.
- err_count  output  ERR_CNT_W  saturating count of illegal-select events.

Behaviour:
- Reset (rst_n low at a clk edge):
  - out_data=0, out_valid=0, sel_err=0, err_count=0.
  - Reset overrides all other events, including a capture or a drain in the same cycle.
- States: EMPTY (out_valid=0) and FULL (out_valid=1).
- in_ready = !out_valid || out_ready (combinational). This gives a full-throughput pipeline stage.
- Legal accept: in_valid && in_ready && in_sel < NUM_IN.
  - Next edge: out_data = input[in_sel], out_valid = 1.
  - Latency: one cycle.
- Illegal event: in_valid && in_sel >= NUM_IN. Applies only when NUM_IN is not a power of two.
  - Counted independent of in_ready; the event is consumed and dropped.
  - Next edge: sel_err = 1 for one cycle.
  - err_count increments and saturates at all-ones.
  - out_data and out_valid are unaffected, except that a simultaneous drain (out_valid && out_ready) still clears out_valid.
- Drain: out_valid && out_ready with no legal accept: next edge out_valid = 0, out_data holds.
- Simultaneous drain and legal accept: out_valid stays 1 and out_data takes the new value.
- FULL && !out_ready: in_ready=0; out_data and out_valid hold; in_valid is ignored apart from illegal-select counting.
- sel_err deasserts on the cycle after any cycle with no illegal event.
- Back-to-back illegal events: sel_err stays high and err_count increments every cycle.
- in_data and in_sel are sampled only at the accept edge; changes while FULL have no effect.

Optional Feature:
- Macro: MUX_REG_SEL_TRACE_EN.
- Defined:
  - Adds output port out_sel (SEL_W bits), captured with out_data on every legal accept and held otherwise.
  - out_sel resets to 0.
  - Used by the control FSM for debug tracing.
- Undefined: port absent; no extra flops; all other behaviour identical.

Decomposition:
- Shared package mux_pkg holds:
  - default WIDTH (32) and ERR_CNT_W (8) constants;
  - the helper function sel_legal(sel, num_in);
  - the typedef for the handshake state enum {EMPTY, FULL}.
- One natural sub-module: sat_counter (parametrised width, increment enable, synchronous active-low clear, saturates at max), instanced for err_count.
- The selection logic stays inline.

Test Plan:
- Reset then basic select: NUM_IN=3, in_data={C,B,A}={32'h3333_3333,32'h2222_2222,32'h1111_1111}, in_sel=1, in_valid=1, out_ready=1 -> next cycle out_data=32'h2222_2222, out_valid=1, sel_err=0.
- Backpressure: FULL, out_ready=0, present in_sel=2 -> in_ready=0, out_data holds 32'h2222_2222; raise out_ready -> same-cycle drain+accept, next cycle out_data=32'h3333_3333, out_valid=1.
- Illegal select: in_sel=3, in_valid=1 -> next cycle sel_err=1 for exactly one cycle, err_count=1, out_data and out_valid unchanged.
- Counter saturation: ERR_CNT_W=2, 5 consecutive illegal events -> err_count sequence 1,2,3,3,3; sel_err high 5 cycles.
- Reset mid-operation: FULL with err_count=2, drive rst_n=0 with a legal accept the same cycle -> next cycle out_valid=0, out_data=0, err_count=0, sel_err=0.
- Width/depth generalisation: NUM_IN=8, WIDTH=16, in_sel=0..7 streamed with out_ready=1 -> out_data matches input k one cycle later, one value per cycle, sel_err never asserted; with MUX_REG_SEL_TRACE_EN, out_sel tracks k.
